// File: rtl/vga_frame_streamer.sv
// 640x480@60 VGA scan-out: timing counters, fixed-latency framebuffer fetch of 4-pixel
// grayscale words, and a 2-clock output pipe. Starts/stops only on frame boundaries.
module vga_frame_streamer #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int ADDR_W    = 17,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              hsync,
  output logic              vsync,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              visible,
  output logic              frame_start,
  output logic              busy
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT_C = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS    = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT_C = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS    = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE    = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_drain;
  logic [HW-1:0]     r_h;
  logic [VW-1:0]     r_v;
  logic [ADDR_W-1:0] r_addr_hold;

  logic              w_run;
  logic              w_frame_end;
  logic              w_fetch;
  logic [ADDR_W-1:0] w_addr;
  logic              w_vis_p0;
  logic              w_hs_p0;
  logic              w_vs_p0;
  logic              w_fs_p0;

  logic              r_vis_p1;
  logic              r_hs_p1;
  logic              r_vs_p1;
  logic              r_fs_p1;
  logic              r_rd_p1;
  logic [1:0]        r_lane_p1;
  logic [31:0]       r_word_p1;
  logic [31:0]       w_word_p1;

  logic              r_vis_p2;
  logic              r_hs_p2;
  logic              r_vs_p2;
  logic              r_fs_p2;
  logic [7:0]        r_pix_p2;

  function automatic logic [7:0] sel_lane(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_state_nxt = S_RUN;
      S_RUN:   if (w_frame_end && !enable) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_drain) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_drain <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drain <= (r_state == S_DRAIN) ? ~r_drain : 1'b0;
    end
  end

  // ---- stage 0: raster counters and framebuffer fetch ----
  assign w_run       = (r_state == S_RUN);
  assign w_frame_end = (r_h == H_LAST) && (r_v == V_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_run) begin
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + VW'(1);
      end else begin
        r_h <= r_h + HW'(1);
      end
    end else begin
      r_h <= '0;
      r_v <= '0;
    end
  end

  assign w_vis_p0 = w_run && (r_h < H_ACT_C) && (r_v < V_ACT_C);
  assign w_fetch  = w_vis_p0 && (r_h[1:0] == 2'b00);
  assign w_addr   = ADDR_W'(32'(BASE_ADDR) + 32'(r_v) * 32'(H_ACTIVE / 4) + 32'(r_h[HW-1:2]));
  assign w_hs_p0  = !(w_run && (r_h >= H_SS) && (r_h < H_SE));
  assign w_vs_p0  = !(w_run && (r_v >= V_SS) && (r_v < V_SE));
  assign w_fs_p0  = w_run && (r_h == '0) && (r_v == '0);

  assign rd_en   = w_fetch;
  assign rd_addr = w_fetch ? w_addr : r_addr_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr_hold <= '0;
    end else if (w_fetch) begin
      r_addr_hold <= w_addr;
    end
  end

  // ---- stage 1: word capture; the lane-0 pixel is taken straight off rd_data ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vis_p1  <= 1'b0;
      r_hs_p1   <= 1'b1;
      r_vs_p1   <= 1'b1;
      r_fs_p1   <= 1'b0;
      r_rd_p1   <= 1'b0;
      r_lane_p1 <= 2'b00;
    end else begin
      r_vis_p1  <= w_vis_p0;
      r_hs_p1   <= w_hs_p0;
      r_vs_p1   <= w_vs_p0;
      r_fs_p1   <= w_fs_p0;
      r_rd_p1   <= w_fetch;
      r_lane_p1 <= r_h[1:0];
    end
  end

  assign w_word_p1 = r_rd_p1 ? rd_data : r_word_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word_p1 <= '0;
    end else begin
      r_word_p1 <= w_word_p1;
    end
  end

  // ---- stage 2: registered outputs, blanked outside the visible area ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vis_p2 <= 1'b0;
      r_hs_p2  <= 1'b1;
      r_vs_p2  <= 1'b1;
      r_fs_p2  <= 1'b0;
      r_pix_p2 <= 8'h00;
    end else begin
      r_vis_p2 <= r_vis_p1;
      r_hs_p2  <= r_hs_p1;
      r_vs_p2  <= r_vs_p1;
      r_fs_p2  <= r_fs_p1;
      r_pix_p2 <= r_vis_p1 ? sel_lane(w_word_p1, r_lane_p1) : 8'h00;
    end
  end

  assign hsync       = r_hs_p2;
  assign vsync       = r_vs_p2;
  assign red         = r_pix_p2;
  assign green       = r_pix_p2;
  assign blue        = r_pix_p2;
  assign visible     = r_vis_p2;
  assign frame_start = r_fs_p2;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_vga_frame_streamer.sv
// Bench for vga_frame_streamer on a shrunken raster; expected outputs come from
// frame arithmetic over a stage-0 cycle index and a word-array memory model.
module tb_vga_frame_streamer;

  localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 6,  VFP = 1, VS = 2, VBP = 2;
  localparam int AW = 17, BASE = 1000;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          hsync, vsync;
  logic [7:0]    red, green, blue;
  logic          visible, frame_start, busy;

  logic [31:0]   mem [0:2047];
  int            n_checks = 0;
  int            n_fail   = 0;

  localparam logic [46:0] IDLE_VEC = {1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 17'h0, 1'b0, 1'b0};

  vga_frame_streamer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .ADDR_W(AW), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .visible(visible), .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  // one-cycle read latency; blanking reads see all-ones so leakage shows up in rgb
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr[10:0]] : 32'hFFFF_FFFF;

  task automatic fill_mem();
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({hsync, vsync, red, green, blue, visible, rd_en, rd_addr, frame_start, busy} !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL reset_values: got %h required %h",
               {hsync, vsync, red, green, blue, visible, rd_en, rd_addr, frame_start, busy}, IDLE_VEC);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({hsync, vsync, red, green, blue, visible, rd_en, rd_addr, frame_start, busy} !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL idle_hold: got %h required %h",
               {hsync, vsync, red, green, blue, visible, rd_en, rd_addr, frame_start, busy}, IDLE_VEC);
    end
  endtask

  task automatic test_first_word();
    logic [7:0] exp_px [4];
    int         waited;
    exp_px = '{8'h11, 8'h22, 8'h33, 8'h44};
    fill_mem();
    mem[BASE] = 32'h4433_2211;
    enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rd_en !== 1'b1 || rd_addr !== AW'(BASE)) begin
      n_fail++;
      $display("FAIL first_fetch: rd_en=%b rd_addr=%0d required rd_en=1 rd_addr=%0d", rd_en, rd_addr, BASE);
    end
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (frame_start !== 1'b1 || visible !== 1'b1) begin
      n_fail++;
      $display("FAIL first_frame_start: frame_start=%b visible=%b required 1 1", frame_start, visible);
    end
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if ({red, green, blue} !== {3{exp_px[j]}}) begin
        n_fail++;
        $display("FAIL first_pixels[%0d]: rgb=%h required %h", j, {red, green, blue}, {3{exp_px[j]}});
      end
      @(negedge clk);
    end
    waited = 0;
    while (busy === 1'b1 && waited < FT + 10) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL first_frame_drain: busy=%b after %0d cycles required 0", busy, waited);
    end
  endtask

  // enable is dropped in cycle drop_at; the frame containing it completes, then drain and idle
  task automatic run_frames(input string name, input int drop_at, input bit toggle);
    int            total, frames, h, v, m, idx;
    int            cnt_rd, cnt_hs, cnt_vs, cnt_fs;
    logic [AW-1:0] last_addr, e_addr;
    logic          e_rd, e_busy, e_vis, e_hs, e_vs, e_fs;
    logic [7:0]    e_pix;
    total  = (drop_at / FT + 1) * FT;
    frames = total / FT;
    cnt_rd = 0; cnt_hs = 0; cnt_vs = 0; cnt_fs = 0;
    last_addr = '0;
    fill_mem();
    enable = 1'b1;
    @(negedge clk);
    for (int n = 0; n <= total + 2; n++) begin
      e_rd   = 1'b0;
      e_addr = last_addr;
      if (n < total) begin
        h = n % HT;
        v = (n / HT) % VT;
        if (h < HA && v < VA && h % 4 == 0) begin
          e_rd   = 1'b1;
          e_addr = AW'(BASE + v * (HA / 4) + h / 4);
        end
      end
      last_addr = e_addr;
      e_busy = (n < total + 2);
      e_vis = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_pix = 8'h00;
      m = n - 2;
      if (m >= 0 && m < total) begin
        h     = m % HT;
        v     = (m / HT) % VT;
        e_vis = (h < HA) && (v < VA);
        e_hs  = !(h >= HA + HFP && h < HA + HFP + HS);
        e_vs  = !(v >= VA + VFP && v < VA + VFP + VS);
        e_fs  = (h == 0) && (v == 0);
        if (e_vis) begin
          idx   = BASE + v * (HA / 4) + h / 4;
          e_pix = 8'(mem[idx] >> (8 * (h % 4)));
        end
      end
      n_checks++;
      if (rd_en !== e_rd || rd_addr !== e_addr) begin
        n_fail++;
        $display("FAIL %s fetch n=%0d: rd_en=%b rd_addr=%0d required %b %0d", name, n, rd_en, rd_addr, e_rd, e_addr);
      end
      n_checks++;
      if (busy !== e_busy) begin
        n_fail++;
        $display("FAIL %s busy n=%0d: got %b required %b", name, n, busy, e_busy);
      end
      n_checks++;
      if ({visible, hsync, vsync, frame_start} !== {e_vis, e_hs, e_vs, e_fs}) begin
        n_fail++;
        $display("FAIL %s timing n=%0d: vis/hs/vs/fs=%b required %b", name, n,
                 {visible, hsync, vsync, frame_start}, {e_vis, e_hs, e_vs, e_fs});
      end
      n_checks++;
      if ({red, green, blue} !== {3{e_pix}}) begin
        n_fail++;
        $display("FAIL %s rgb n=%0d: got %h required %h", name, n, {red, green, blue}, {3{e_pix}});
      end
      if (rd_en === 1'b1) cnt_rd++;
      if (hsync === 1'b0) cnt_hs++;
      if (vsync === 1'b0) cnt_vs++;
      if (frame_start === 1'b1) cnt_fs++;
      if (n >= drop_at)          enable = 1'b0;
      else if (n % FT == FT - 1) enable = 1'b1;
      else if (toggle)           enable = 1'($urandom_range(0, 1));
      else                       enable = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (cnt_rd != frames * (HA / 4) * VA) begin
      n_fail++;
      $display("FAIL %s rd_en_count: got %0d required %0d", name, cnt_rd, frames * (HA / 4) * VA);
    end
    n_checks++;
    if (cnt_hs != frames * VT * HS) begin
      n_fail++;
      $display("FAIL %s hsync_low_count: got %0d required %0d", name, cnt_hs, frames * VT * HS);
    end
    n_checks++;
    if (cnt_vs != frames * VS * HT) begin
      n_fail++;
      $display("FAIL %s vsync_low_count: got %0d required %0d", name, cnt_vs, frames * VS * HT);
    end
    n_checks++;
    if (cnt_fs != frames) begin
      n_fail++;
      $display("FAIL %s frame_start_count: got %0d required %0d", name, cnt_fs, frames);
    end
  endtask

  task automatic test_full_frames();
    run_frames("full_frames", FT + 5 * HT + 7, 1'b1);
  endtask

  task automatic test_reset_midframe();
    enable = 1'b1;
    repeat (HT + 8) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({hsync, vsync, red, green, blue, visible, rd_en, rd_addr, frame_start, busy} !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL reset_midframe: got %h required %h",
               {hsync, vsync, red, green, blue, visible, rd_en, rd_addr, frame_start, busy}, IDLE_VEC);
    end
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({hsync, vsync, red, green, blue, visible, rd_en, rd_addr, frame_start, busy} !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %h required %h",
               {hsync, vsync, red, green, blue, visible, rd_en, rd_addr, frame_start, busy}, IDLE_VEC);
    end
  endtask

  task automatic test_back_to_back();
    run_frames("single_frame_early_drop", 0, 1'b0);
    run_frames("single_frame_late_drop", FT - 1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_full_frames();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
